// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher: one round per clock, round keys fetched by index.
// Define AES_DECIPHER_WORD_SERIAL_EN for a 4-sbox datapath that spends four clocks per round.

module aes_inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // Entry 0 sits in the most significant byte, so the table reads in natural order.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign o_byte = INV_SBOX[i_byte];
endmodule

module aes_decipher_block #(
  parameter logic [3:0] NR128 = 4'd10,
  parameter logic [3:0] NR256 = 4'd14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  typedef enum logic [1:0] {
    CTRL_IDLE,
    CTRL_INIT,
    CTRL_MAIN,
    CTRL_FINAL
  } ctrl_e;

  ctrl_e        r_ctrl;
  logic [127:0] r_state;
  logic [127:0] r_new_block;
  logic [3:0]   r_round;
  logic         r_ready;

  logic [127:0] w_subbed;
  logic [127:0] w_state_partial;
  logic [127:0] w_ark;
  logic [127:0] w_imc;
  logic         w_round_last;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = gf_xtime(a[i]);
      x4    = gf_xtime(x2);
      x8    = gf_xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
    return o;
  endfunction

  // Row r rotates right by r columns: out[r][c] takes in[r][c-r].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

`ifdef AES_DECIPHER_WORD_SERIAL_EN
  logic [1:0]  r_word_ctr;
  logic [31:0] w_sb_in;
  logic [31:0] w_sb_out;

  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_sb_in = r_state[31:0];
    case (r_word_ctr)
      2'd0:    w_sb_in = r_state[127:96];
      2'd1:    w_sb_in = r_state[95:64];
      2'd2:    w_sb_in = r_state[63:32];
      default: w_sb_in = r_state[31:0];
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .i_byte (w_sb_in[31-8*g -: 8]),
      .o_byte (w_sb_out[31-8*g -: 8])
    );
  end

  // Substitution is bytewise, so it can run on unshifted words and the shift follows on word 3.
  always_comb begin
    w_state_partial = r_state;
    case (r_word_ctr)
      2'd0:    w_state_partial[127:96] = w_sb_out;
      2'd1:    w_state_partial[95:64]  = w_sb_out;
      2'd2:    w_state_partial[63:32]  = w_sb_out;
      default: w_state_partial[31:0]   = w_sb_out;
    endcase
  end

  assign w_subbed     = inv_shift_rows(w_state_partial);
  assign w_round_last = (r_word_ctr == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_word_ctr <= 2'd0;
    end else if (r_ctrl == CTRL_MAIN || r_ctrl == CTRL_FINAL) begin
      r_word_ctr <= r_word_ctr + 2'd1;
    end else begin
      r_word_ctr <= 2'd0;
    end
  end
`else
  logic [127:0] w_isr;

  assign w_isr = inv_shift_rows(r_state);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .i_byte (w_isr[127-8*g -: 8]),
      .o_byte (w_subbed[127-8*g -: 8])
    );
  end

  assign w_state_partial = r_state;
  assign w_round_last    = 1'b1;
`endif

  assign w_ark = w_subbed ^ round_key;
  assign w_imc = inv_mix_columns(w_ark);

  // The round register doubles as the round counter: it already holds 0 in FINAL and IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl      <= CTRL_IDLE;
      r_state     <= '0;
      r_new_block <= '0;
      r_round     <= '0;
      r_ready     <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_ctrl)
        CTRL_IDLE: begin
          if (next) begin
            r_state <= block;
            r_round <= keylen ? NR256 : NR128;
            r_ready <= 1'b0;
            r_ctrl  <= CTRL_INIT;
          end
        end
        CTRL_INIT: begin
          r_state <= r_state ^ round_key;
          r_round <= r_round - 4'd1;
          r_ctrl  <= CTRL_MAIN;
        end
        CTRL_MAIN: begin
          if (w_round_last) begin
            r_state <= w_imc;
            r_round <= r_round - 4'd1;
            if (r_round == 4'd1) r_ctrl <= CTRL_FINAL;
          end else begin
            r_state <= w_state_partial;
          end
        end
        CTRL_FINAL: begin
          if (w_round_last) begin
            r_new_block <= w_ark;
            r_ready     <= 1'b1;
            r_ctrl      <= CTRL_IDLE;
          end else begin
            r_state <= w_state_partial;
          end
        end
        default: r_ctrl <= CTRL_IDLE;
      endcase
    end
  end

  assign round     = r_round;
  assign new_block = r_new_block;
  assign ready     = r_ready;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Directed bench for aes_decipher_block: FIPS-197 vectors against a bench-side key schedule model.
// Honours AES_DECIPHER_WORD_SERIAL_EN for the expected latency and round sequence.

module tb_aes_decipher_block;

`ifdef AES_DECIPHER_WORD_SERIAL_EN
  localparam int SERIAL = 4;
`else
  localparam int SERIAL = 1;
`endif

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KB    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  logic [127:0] keys [0:15];
  logic [7:0]   fwd_sbox [256];
  int           n_checks;
  int           n_fail;

  aes_decipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  // Key memory model: combinational lookup by the requested index.
  assign round_key = keys[round];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Forward S-box built from the field inverse and the affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {fwd_sbox[w[31:24]], fwd_sbox[w[23:16]], fwd_sbox[w[15:8]], fwd_sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = xtime(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic int exp_round(input int nr, input int c);
    if (c == 0) return nr;
    return nr - 1 - (c - 1) / SERIAL;
  endfunction

  // mode: 0 plain, 1 next pulses while busy, 2 next in the final busy cycle, 3 reset at busy cycle 5.
  task automatic do_op(input logic kl, input logic [255:0] key, input logic [127:0] ct,
                       input logic [127:0] pt, input logic [127:0] hold, input int mode);
    int nr;
    int lat;
    int c;
    nr  = kl ? 14 : 10;
    lat = SERIAL * nr + 1;
    expand_key(key, kl ? 8 : 4);
    keylen = kl;
    block  = ct;
    next   = 1'b1;
    @(negedge clk);
    next   = 1'b0;
    keylen = ~kl;
    block  = ~ct;
    c = 0;
    while (c < 200 && ready !== 1'b1) begin
      check("round", 128'(round), 128'(exp_round(nr, c)));
      check("hold", new_block, hold);
      if (mode == 3 && c == 5) begin
        reset_n = 1'b0;
        #1;
        check("rst_ready", 128'(ready), 128'(1));
        check("rst_new_block", new_block, 128'h0);
        check("rst_round", 128'(round), 128'h0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      next  = (mode == 1 && (c == 3 || c == 7)) || (mode == 2 && c == lat - 1);
      block = ct ^ 128'(c + 1);
      @(negedge clk);
      c++;
    end
    next = 1'b0;
    check("latency", 128'(c), 128'(lat));
    check("result", new_block, pt);
    check("idle_round", 128'(round), 128'h0);
    if (mode == 2) begin
      @(negedge clk);
      check("final_next_ignored", 128'(ready), 128'(1));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    next     = 1'b0;
    keylen   = 1'b0;
    block    = '0;
    for (int i = 0; i < 16; i++) keys[i] = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 128'(ready), 128'(1));
    check("reset_new_block", new_block, 128'h0);
    check("reset_round", 128'(round), 128'h0);

    do_op(1'b0, {K128, 128'h0}, C1_CT, PT, 128'h0, 0);
    do_op(1'b1, K256, C3_CT, PT, PT, 2);
    do_op(1'b0, {KB, 128'h0}, B_CT, B_PT, PT, 0);
    do_op(1'b0, {K128, 128'h0}, C1_CT, PT, B_PT, 1);
    do_op(1'b1, K256, C3_CT, PT, PT, 3);
    do_op(1'b0, {K128, 128'h0}, C1_CT, PT, 128'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
